hazard_forward_unit: RTL and testbench

//  Parametrised forwarding + load-use hazard unit for the 5-stage core; next generation of the 2-port forwarding logic.
//  - Supports NPORT source operands.
//  - Keeps HIST_DEPTH cycles of retired writes (data included) after WB.
//  - Never forwards x0.
//  - Generates load-use stall/bubble through a small counter FSM.

---
 rtl/hazard_forward_unit_pkg.sv | 25 ++
 rtl/hazard_forward_unit_if.sv | 43 ++++
 rtl/hazard_forward_unit_fwd_sel_port.sv | 39 +++
 rtl/hazard_forward_unit.sv | 143 ++++++++++++++
 tb/tb_hazard_forward_unit.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_forward_unit_pkg.sv
// Shared types and constants for the forwarding / load-use hazard unit.
// The fwd_sel encoding is 0=regfile, 1=MEM, 2=WB, and 3+k for history entry k.
package hazard_forward_unit_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } hfu_state_e;

  localparam int REGW      = 5;
  localparam int FWD_RF    = 0;
  localparam int FWD_MEM   = 1;
  localparam int FWD_WB    = 2;
  localparam int FWD_HIST0 = 3;

  function automatic int selWidth(input int histDepth);
    return $clog2(3 + histDepth);
  endfunction

  // With no history we still keep one slot so vector widths never collapse to zero.
  function automatic int histSlots(input int histDepth);
    return (histDepth > 0) ? histDepth : 1;
  endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Pipeline-side bundle of the hazard unit.
// The pipeline drives it through the master modport, and the unit through the slave modport.
interface hazard_forward_unit_if
  import hazard_forward_unit_pkg::*;
#(
  parameter int NPORT      = 2,
  parameter int HIST_DEPTH = 1,
  parameter int XLEN       = 32
);

  localparam int SELW  = selWidth(HIST_DEPTH);
  localparam int HSLOT = histSlots(HIST_DEPTH);

  logic [NPORT*REGW-1:0]  rs;
  logic [NPORT-1:0]       rs_valid;
  logic [NPORT*REGW-1:0]  rs_d;
  logic [NPORT-1:0]       rs_d_valid;
  logic [REGW-1:0]        rd_e;
  logic                   memread_e;
  logic [REGW-1:0]        rd_m;
  logic                   regwrite_m;
  logic [REGW-1:0]        rd_w;
  logic                   regwrite_w;
  logic [XLEN-1:0]        wdata_w;
  logic                   eflush;
  logic [NPORT*SELW-1:0]  fwd_sel;
  logic [HSLOT*XLEN-1:0]  hist_wdata;
  logic                   stall_d;
  logic                   bubble_e;

  modport master (
    output rs, rs_valid, rs_d, rs_d_valid, rd_e, memread_e,
           rd_m, regwrite_m, rd_w, regwrite_w, wdata_w, eflush,
    input  fwd_sel, hist_wdata, stall_d, bubble_e
  );

  modport slave (
    input  rs, rs_valid, rs_d, rs_d_valid, rd_e, memread_e,
           rd_m, regwrite_m, rd_w, regwrite_w, wdata_w, eflush,
    output fwd_sel, hist_wdata, stall_d, bubble_e
  );

endinterface

// File: rtl/hazard_forward_unit_fwd_sel_port.sv
// Priority encoder that picks the forwarding source for one operand port.
// The youngest producer wins: MEM, then WB, then history from the newest entry to the oldest.
module fwd_sel_port
  import hazard_forward_unit_pkg::*;
#(
  parameter  int HIST_DEPTH = 1,
  parameter  int SELW       = 2,
  localparam int HSLOT      = histSlots(HIST_DEPTH)
) (
  input  logic [REGW-1:0]       rs_i,
  input  logic                  rs_valid_i,
  input  logic [REGW-1:0]       rd_m_i,
  input  logic                  regwrite_m_i,
  input  logic [REGW-1:0]       rd_w_i,
  input  logic                  regwrite_w_i,
  input  logic [HSLOT*REGW-1:0] hist_rd_i,
  input  logic [HSLOT-1:0]      hist_vld_i,
  output logic [SELW-1:0]       sel_o
);

  // Checks run oldest-first so that each later (younger) match overrides an earlier one.
  always_comb begin
    sel_o = SELW'(FWD_RF);
    if (rs_valid_i && (rs_i != '0)) begin
      for (int k = HIST_DEPTH - 1; k >= 0; k--) begin
        if (hist_vld_i[k] && (hist_rd_i[k*REGW +: REGW] == rs_i)) begin
          sel_o = SELW'(FWD_HIST0 + k);
        end
      end
      if (regwrite_w_i && (rd_w_i == rs_i)) begin
        sel_o = SELW'(FWD_WB);
      end
      if (regwrite_m_i && (rd_m_i == rs_i)) begin
        sel_o = SELW'(FWD_MEM);
      end
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Forwarding select for NPORT operands, plus a history of retired writes and a load-use stall FSM.
// It sits beside ID/EX and drives the EX operand muxes, the IF/ID hold and the ID/EX bubble.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter  int NPORT      = 2,
  parameter  int HIST_DEPTH = 1,
  parameter  int LOAD_LAT   = 1,
  parameter  int XLEN       = 32,
  localparam int SELW       = selWidth(HIST_DEPTH),
  localparam int HSLOT      = histSlots(HIST_DEPTH),
  localparam int CNTW       = $clog2(LOAD_LAT + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  hazard_forward_unit_if.slave  bus
);

  logic [HSLOT-1:0]      histVld;
  logic [HSLOT*REGW-1:0] histRd;
  logic [NPORT*SELW-1:0] fwdSel;
  logic                  loadUseHz;
  logic                  stallD;
  logic                  bubbleE;
  hfu_state_e            state_q, state_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;

  if (HIST_DEPTH > 0) begin : gen_hist
    logic [HIST_DEPTH-1:0]      histWe_q;
    logic [HIST_DEPTH*REGW-1:0] histRd_q;
    logic [HIST_DEPTH*XLEN-1:0] histData_q;

    // The history keeps shifting while the pipeline is stalled, because WB keeps retiring.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        histWe_q   <= '0;
        histRd_q   <= '0;
        histData_q <= '0;
      end else begin
        histWe_q[0]          <= bus.regwrite_w;
        histRd_q[0 +: REGW]  <= bus.rd_w;
        histData_q[0 +: XLEN] <= bus.wdata_w;
        for (int k = 1; k < HIST_DEPTH; k++) begin
          histWe_q[k]               <= histWe_q[k-1];
          histRd_q[k*REGW +: REGW]  <= histRd_q[(k-1)*REGW +: REGW];
          histData_q[k*XLEN +: XLEN] <= histData_q[(k-1)*XLEN +: XLEN];
        end
      end
    end

    always_comb begin
      histVld = '0;
      for (int k = 0; k < HIST_DEPTH; k++) begin
        histVld[k] = histWe_q[k] && (histRd_q[k*REGW +: REGW] != '0);
      end
    end

    assign histRd         = histRd_q;
    assign bus.hist_wdata = histData_q;
  end else begin : gen_no_hist
    assign histVld        = '0;
    assign histRd         = '0;
    assign bus.hist_wdata = '0;
  end

  for (genvar i = 0; i < NPORT; i++) begin : gen_port
    fwd_sel_port #(
      .HIST_DEPTH (HIST_DEPTH),
      .SELW       (SELW)
    ) u_port (
      .rs_i         (bus.rs[i*REGW +: REGW]),
      .rs_valid_i   (bus.rs_valid[i]),
      .rd_m_i       (bus.rd_m),
      .regwrite_m_i (bus.regwrite_m),
      .rd_w_i       (bus.rd_w),
      .regwrite_w_i (bus.regwrite_w),
      .hist_rd_i    (histRd),
      .hist_vld_i   (histVld),
      .sel_o        (fwdSel[i*SELW +: SELW])
    );
  end

  assign bus.fwd_sel = fwdSel;

  always_comb begin
    loadUseHz = 1'b0;
    if (bus.memread_e && (bus.rd_e != '0) && !bus.eflush) begin
      for (int i = 0; i < NPORT; i++) begin
        if (bus.rs_d_valid[i] && (bus.rs_d[i*REGW +: REGW] == bus.rd_e)) begin
          loadUseHz = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The hazard cycle is the first stall cycle, so STALL covers only the remaining LOAD_LAT-1 cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stallD  = 1'b0;
    bubbleE = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (loadUseHz) begin
          stallD  = 1'b1;
          bubbleE = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = ST_STALL;
            cnt_d   = CNTW'(LOAD_LAT - 1);
          end
        end
      end
      ST_STALL: begin
        if (bus.eflush) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          stallD  = 1'b1;
          bubbleE = 1'b1;
          cnt_d   = cnt_q - CNTW'(1);
          if (cnt_q == CNTW'(1)) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.stall_d  = stallD;
  assign bus.bubble_e = bubbleE;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed scoreboard bench for two configurations of hazard_forward_unit driven with identical stimulus.
// Configuration A uses a deep history and slow loads; configuration B uses the default parameters.
module tb_hazard_forward_unit;
  import hazard_forward_unit_pkg::*;

  typedef struct packed {
    logic [9:0]  rs;
    logic [1:0]  rs_valid;
    logic [9:0]  rs_d;
    logic [1:0]  rs_d_valid;
    logic [4:0]  rd_e;
    logic        memread_e;
    logic [4:0]  rd_m;
    logic        regwrite_m;
    logic [4:0]  rd_w;
    logic        regwrite_w;
    logic [31:0] wdata_w;
    logic        eflush;
  } stim_t;

  typedef enum int {
    OBS_SEL_A0, OBS_SEL_A1, OBS_SEL_B0, OBS_SEL_B1,
    OBS_STALL_A, OBS_BUB_A, OBS_STALL_B, OBS_BUB_B,
    OBS_HIST_A0, OBS_HIST_A1, OBS_HIST_B0
  } obs_e;

  typedef struct {
    string       tag;
    obs_e        what;
    logic [31:0] value;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst;
  stim_t stim;
  exp_t  sbQ[$];
  int    testCount = 0;
  int    failCount = 0;

  always #5 clk = ~clk;

  hazard_forward_unit_if #(.NPORT(2), .HIST_DEPTH(2), .XLEN(32)) ifA ();
  hazard_forward_unit_if #(.NPORT(2), .HIST_DEPTH(1), .XLEN(32)) ifB ();

  hazard_forward_unit #(.NPORT(2), .HIST_DEPTH(2), .LOAD_LAT(3), .XLEN(32)) dutA (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifA)
  );

  hazard_forward_unit #(.NPORT(2), .HIST_DEPTH(1), .LOAD_LAT(1), .XLEN(32)) dutB (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifB)
  );

  assign ifA.rs         = stim.rs;
  assign ifA.rs_valid   = stim.rs_valid;
  assign ifA.rs_d       = stim.rs_d;
  assign ifA.rs_d_valid = stim.rs_d_valid;
  assign ifA.rd_e       = stim.rd_e;
  assign ifA.memread_e  = stim.memread_e;
  assign ifA.rd_m       = stim.rd_m;
  assign ifA.regwrite_m = stim.regwrite_m;
  assign ifA.rd_w       = stim.rd_w;
  assign ifA.regwrite_w = stim.regwrite_w;
  assign ifA.wdata_w    = stim.wdata_w;
  assign ifA.eflush     = stim.eflush;
  assign ifB.rs         = stim.rs;
  assign ifB.rs_valid   = stim.rs_valid;
  assign ifB.rs_d       = stim.rs_d;
  assign ifB.rs_d_valid = stim.rs_d_valid;
  assign ifB.rd_e       = stim.rd_e;
  assign ifB.memread_e  = stim.memread_e;
  assign ifB.rd_m       = stim.rd_m;
  assign ifB.regwrite_m = stim.regwrite_m;
  assign ifB.rd_w       = stim.rd_w;
  assign ifB.regwrite_w = stim.regwrite_w;
  assign ifB.wdata_w    = stim.wdata_w;
  assign ifB.eflush     = stim.eflush;

  function automatic logic [31:0] observe(input obs_e w);
    case (w)
      OBS_SEL_A0:  return 32'(ifA.fwd_sel[2:0]);
      OBS_SEL_A1:  return 32'(ifA.fwd_sel[5:3]);
      OBS_SEL_B0:  return 32'(ifB.fwd_sel[1:0]);
      OBS_SEL_B1:  return 32'(ifB.fwd_sel[3:2]);
      OBS_STALL_A: return 32'(ifA.stall_d);
      OBS_BUB_A:   return 32'(ifA.bubble_e);
      OBS_STALL_B: return 32'(ifB.stall_d);
      OBS_BUB_B:   return 32'(ifB.bubble_e);
      OBS_HIST_A0: return ifA.hist_wdata[31:0];
      OBS_HIST_A1: return ifA.hist_wdata[63:32];
      OBS_HIST_B0: return ifB.hist_wdata[31:0];
      default:     return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic applyStimulus(input stim_t s);
    stim = s;
  endtask

  task automatic pushExpect(input string tag, input obs_e w, input logic [31:0] v);
    exp_t e;
    e.tag   = tag;
    e.what  = w;
    e.value = v;
    sbQ.push_back(e);
  endtask

  // Outputs are sampled mid-cycle, then the bench advances to just past the next rising edge.
  task automatic checkOutput();
    exp_t        e;
    logic [31:0] obs;
    #2;
    while (sbQ.size() > 0) begin
      e   = sbQ.pop_front();
      obs = observe(e.what);
      testCount++;
      assert (obs === e.value)
      else begin
        failCount++;
        $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.value);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    stim_t s;
    s   = '0;
    rst = 1'b1;
    applyStimulus(s);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    pushExpect("rst_stallA", OBS_STALL_A, 0);
    pushExpect("rst_bubA", OBS_BUB_A, 0);
    pushExpect("rst_stallB", OBS_STALL_B, 0);
    pushExpect("rst_histA0", OBS_HIST_A0, 0);
    pushExpect("rst_histA1", OBS_HIST_A1, 0);
    pushExpect("rst_histB0", OBS_HIST_B0, 0);
    pushExpect("rst_selA0", OBS_SEL_A0, 0);
    checkOutput();

    s = '0; s.rs[4:0] = 5'd1; s.rs_valid = 2'b01;
    s.rd_m = 5'd1; s.regwrite_m = 1'b1; s.rd_w = 5'd1; s.regwrite_w = 1'b1; s.wdata_w = 32'h1111;
    applyStimulus(s);
    pushExpect("memWinsA", OBS_SEL_A0, FWD_MEM);
    pushExpect("memWinsB", OBS_SEL_B0, FWD_MEM);
    pushExpect("port1IdleA", OBS_SEL_A1, FWD_RF);
    checkOutput();
    s.regwrite_m = 1'b0;
    applyStimulus(s);
    pushExpect("wbOverHistA", OBS_SEL_A0, FWD_WB);
    pushExpect("wbOverHistB", OBS_SEL_B0, FWD_WB);
    checkOutput();
    s.rs_valid = 2'b00; s.regwrite_w = 1'b0;
    applyStimulus(s);
    pushExpect("noValidA", OBS_SEL_A0, FWD_RF);
    pushExpect("noValidB", OBS_SEL_B0, FWD_RF);
    checkOutput();

    s = '0; s.rs_valid = 2'b11; s.rd_m = 5'd0; s.regwrite_m = 1'b1; s.rd_w = 5'd0; s.regwrite_w = 1'b1;
    applyStimulus(s);
    pushExpect("x0A0", OBS_SEL_A0, FWD_RF);
    pushExpect("x0A1", OBS_SEL_A1, FWD_RF);
    pushExpect("x0B0", OBS_SEL_B0, FWD_RF);
    checkOutput();
    s = '0;
    applyStimulus(s);
    checkOutput();
    checkOutput();

    s = '0; s.rd_w = 5'd5; s.regwrite_w = 1'b1; s.wdata_w = 32'hDEAD; s.rs[4:0] = 5'd5; s.rs_valid = 2'b01;
    applyStimulus(s);
    pushExpect("x5wbA", OBS_SEL_A0, FWD_WB);
    checkOutput();
    s = '0; s.rs = {5'd5, 5'd5}; s.rs_valid = 2'b11;
    applyStimulus(s);
    pushExpect("hist0selA0", OBS_SEL_A0, FWD_HIST0);
    pushExpect("hist0selA1", OBS_SEL_A1, FWD_HIST0);
    pushExpect("hist0selB0", OBS_SEL_B0, FWD_HIST0);
    pushExpect("hist0selB1", OBS_SEL_B1, FWD_HIST0);
    pushExpect("hist0dataA", OBS_HIST_A0, 32'hDEAD);
    pushExpect("hist0dataB", OBS_HIST_B0, 32'hDEAD);
    checkOutput();
    pushExpect("hist1selA0", OBS_SEL_A0, FWD_HIST0 + 1);
    pushExpect("hist1dataA", OBS_HIST_A1, 32'hDEAD);
    pushExpect("hist0emptyA", OBS_HIST_A0, 0);
    pushExpect("histGoneB", OBS_SEL_B0, FWD_RF);
    pushExpect("histGoneDataB", OBS_HIST_B0, 0);
    checkOutput();

    s = '0; s.rd_w = 5'd6; s.regwrite_w = 1'b1; s.wdata_w = 32'hA;
    applyStimulus(s);
    checkOutput();
    s.wdata_w = 32'hB;
    applyStimulus(s);
    checkOutput();
    s = '0; s.rs[4:0] = 5'd6; s.rs_valid = 2'b01;
    applyStimulus(s);
    pushExpect("lowestKselA", OBS_SEL_A0, FWD_HIST0);
    pushExpect("lowestKd0A", OBS_HIST_A0, 32'hB);
    pushExpect("lowestKd1A", OBS_HIST_A1, 32'hA);
    pushExpect("lowestKselB", OBS_SEL_B0, FWD_HIST0);
    checkOutput();
    s.rd_m = 5'd6; s.regwrite_m = 1'b1;
    applyStimulus(s);
    pushExpect("memOverHistA", OBS_SEL_A0, FWD_MEM);
    checkOutput();

    s = '0; s.memread_e = 1'b1; s.rd_e = 5'd7; s.rs_d[9:5] = 5'd7; s.rs_d_valid = 2'b10;
    applyStimulus(s);
    pushExpect("lu1stallA", OBS_STALL_A, 1);
    pushExpect("lu1bubA", OBS_BUB_A, 1);
    pushExpect("lu1stallB", OBS_STALL_B, 1);
    pushExpect("lu1bubB", OBS_BUB_B, 1);
    checkOutput();
    s.memread_e = 1'b0;
    applyStimulus(s);
    pushExpect("lu2stallA", OBS_STALL_A, 1);
    pushExpect("lu2bubA", OBS_BUB_A, 1);
    pushExpect("lu2stallB", OBS_STALL_B, 0);
    pushExpect("lu2bubB", OBS_BUB_B, 0);
    checkOutput();
    pushExpect("lu3stallA", OBS_STALL_A, 1);
    pushExpect("lu3bubA", OBS_BUB_A, 1);
    checkOutput();
    pushExpect("lu4stallA", OBS_STALL_A, 0);
    pushExpect("lu4bubA", OBS_BUB_A, 0);
    checkOutput();
    s.memread_e = 1'b1; s.rs_d_valid = 2'b00;
    applyStimulus(s);
    pushExpect("luNoValidA", OBS_STALL_A, 0);
    pushExpect("luNoValidB", OBS_STALL_B, 0);
    checkOutput();
    s.rd_e = 5'd0; s.rs_d = '0; s.rs_d_valid = 2'b01;
    applyStimulus(s);
    pushExpect("luX0A", OBS_STALL_A, 0);
    pushExpect("luX0B", OBS_STALL_B, 0);
    checkOutput();

    s = '0; s.memread_e = 1'b1; s.rd_e = 5'd7; s.rs_d[9:5] = 5'd7; s.rs_d_valid = 2'b10;
    applyStimulus(s);
    pushExpect("efStartA", OBS_STALL_A, 1);
    checkOutput();
    s.memread_e = 1'b0; s.eflush = 1'b1;
    applyStimulus(s);
    pushExpect("efAbortStallA", OBS_STALL_A, 0);
    pushExpect("efAbortBubA", OBS_BUB_A, 0);
    checkOutput();
    s.eflush = 1'b0;
    applyStimulus(s);
    pushExpect("efIdleStallA", OBS_STALL_A, 0);
    pushExpect("efIdleBubA", OBS_BUB_A, 0);
    checkOutput();
    s.memread_e = 1'b1; s.eflush = 1'b1;
    applyStimulus(s);
    pushExpect("hzFlushA", OBS_STALL_A, 0);
    pushExpect("hzFlushBubA", OBS_BUB_A, 0);
    pushExpect("hzFlushB", OBS_STALL_B, 0);
    checkOutput();
    s.memread_e = 1'b0; s.eflush = 1'b0;
    applyStimulus(s);
    pushExpect("hzFlushAfterA", OBS_STALL_A, 0);
    checkOutput();

    s = '0; s.rd_w = 5'd9; s.regwrite_w = 1'b1; s.wdata_w = 32'h99;
    applyStimulus(s);
    checkOutput();
    s.wdata_w = 32'h98; s.memread_e = 1'b1; s.rd_e = 5'd7; s.rs_d[9:5] = 5'd7; s.rs_d_valid = 2'b10;
    applyStimulus(s);
    pushExpect("preRstStartA", OBS_STALL_A, 1);
    checkOutput();
    s = '0; s.rs[4:0] = 5'd9; s.rs_valid = 2'b01;
    applyStimulus(s);
    rst = 1'b1;
    pushExpect("preRstStallA", OBS_STALL_A, 1);
    pushExpect("preRstHistA0", OBS_HIST_A0, 32'h98);
    pushExpect("preRstHistA1", OBS_HIST_A1, 32'h99);
    pushExpect("preRstHistB0", OBS_HIST_B0, 32'h98);
    pushExpect("preRstSelA", OBS_SEL_A0, FWD_HIST0);
    pushExpect("preRstSelB", OBS_SEL_B0, FWD_HIST0);
    checkOutput();
    rst = 1'b0;
    pushExpect("postRstStallA", OBS_STALL_A, 0);
    pushExpect("postRstBubA", OBS_BUB_A, 0);
    pushExpect("postRstHistA0", OBS_HIST_A0, 0);
    pushExpect("postRstHistA1", OBS_HIST_A1, 0);
    pushExpect("postRstHistB0", OBS_HIST_B0, 0);
    pushExpect("postRstSelA", OBS_SEL_A0, FWD_RF);
    pushExpect("postRstSelB", OBS_SEL_B0, FWD_RF);
    checkOutput();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
